// File: rtl/smi_tx_word_packer_pkg.sv
// Shared definitions for the SMI TX word packer and the LVDS transmitter:
// frame sync patterns, byte ordering within a frame and the packer FSM encoding.
package smi_tx_word_packer_pkg;

    localparam logic [1:0] SyncI = 2'b10;
    localparam logic [1:0] SyncQ = 2'b01;

    localparam int unsigned FrameBytes = 4;

    typedef enum logic [1:0] {
        StHunt = 2'b00,
        StB1   = 2'b01,
        StB2   = 2'b10,
        StB3   = 2'b11
    } state_e;

    // Frames are sent MSB first: byte index 0 lands in [31:24], index 3 in [7:0].
    function automatic int unsigned lane_lsb(input int unsigned idx);
        return 8 * (FrameBytes - 1 - idx);
    endfunction

    function automatic logic [1:0] sync_bits(input logic [7:0] b);
        return b[7:6];
    endfunction

endpackage

// File: rtl/smi_tx_word_packer_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, clears only on reset.
module smi_tx_word_packer_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/smi_tx_word_packer.sv
// Packs SMI bytes into 32-bit I/Q frames for the TX FIFO, hunting on the I/Q sync bits.
// Diagnostic counters are built only when SMI_TX_PACKER_STATS_EN is defined.
module smi_tx_word_packer
    import smi_tx_word_packer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_sys_clk,
    input  logic             i_rst_b,
    input  logic             i_enable,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    input  logic             i_fifo_full,
    output logic             o_fifo_push,
    output logic [31:0]      o_fifo_data,
    output logic [CNT_W-1:0] o_sync_err_count,
    output logic [CNT_W-1:0] o_drop_count,
    output logic             o_aligned
);

    state_e      state_d, state_q;
    logic [31:0] word_d, word_q;
    logic        push_d, push_q;
    logic [31:0] data_d, data_q;
    logic [31:0] frame;
    logic        sync_err_inc;
    logic        drop_inc;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        push_d       = 1'b0;
        data_d       = data_q;
        sync_err_inc = 1'b0;
        drop_inc     = 1'b0;
        frame        = word_q;
        frame[lane_lsb(3) +: 8] = i_byte;

        if (!i_enable) begin
            state_d = StHunt;
            word_d  = '0;
        end else if (i_byte_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (sync_bits(i_byte) == SyncI) begin
                        word_d[lane_lsb(0) +: 8] = i_byte;
                        state_d = StB1;
                    end
                end
                StB1: begin
                    word_d[lane_lsb(1) +: 8] = i_byte;
                    state_d = StB2;
                end
                StB2: begin
                    if (sync_bits(i_byte) == SyncQ) begin
                        word_d[lane_lsb(2) +: 8] = i_byte;
                        state_d = StB3;
                    end else begin
                        sync_err_inc = 1'b1;
                        // A slipped stream may already be showing the next I byte.
                        if (sync_bits(i_byte) == SyncI) begin
                            word_d = '0;
                            word_d[lane_lsb(0) +: 8] = i_byte;
                            state_d = StB1;
                        end else begin
                            state_d = StHunt;
                        end
                    end
                end
                StB3: begin
                    state_d = StHunt;
                    word_d  = '0;
                    if (!i_fifo_full) begin
                        push_d = 1'b1;
                        data_d = frame;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q <= StHunt;
            word_q  <= '0;
            push_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            push_q  <= push_d;
            data_q  <= data_d;
        end
    end

    assign o_fifo_push = push_q;
    assign o_fifo_data = data_q;
    assign o_aligned   = (state_q != StHunt);

`ifdef SMI_TX_PACKER_STATS_EN
    smi_tx_word_packer_sat_counter #(
        .Width (CNT_W)
    ) u_sync_err_cnt (
        .clk_i   (i_sys_clk),
        .rst_ni  (i_rst_b),
        .inc_i   (sync_err_inc),
        .count_o (o_sync_err_count)
    );

    smi_tx_word_packer_sat_counter #(
        .Width (CNT_W)
    ) u_drop_cnt (
        .clk_i   (i_sys_clk),
        .rst_ni  (i_rst_b),
        .inc_i   (drop_inc),
        .count_o (o_drop_count)
    );
`else
    logic unused_inc;
    assign unused_inc       = sync_err_inc | drop_inc;
    assign o_sync_err_count = '0;
    assign o_drop_count     = '0;
`endif

endmodule

// File: tb/tb_smi_tx_word_packer.sv
// Bench for smi_tx_word_packer: directed test-plan sequences plus random bytes,
// checked against a queue-based frame model. Two DUTs share stimulus (CNT_W 16 and 2).
module tb_smi_tx_word_packer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        en;
    logic        bv;
    logic [7:0]  b;
    logic        full;

    logic        push_a, push_s;
    logic [31:0] data_a, data_s;
    logic [15:0] err_a, drop_a;
    logic [1:0]  err_s, drop_s;
    logic        al_a, al_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    smi_tx_word_packer #(.CNT_W(16)) u_dut (
        .i_sys_clk        (clk),
        .i_rst_b          (rst_b),
        .i_enable         (en),
        .i_byte_valid     (bv),
        .i_byte           (b),
        .i_fifo_full      (full),
        .o_fifo_push      (push_a),
        .o_fifo_data      (data_a),
        .o_sync_err_count (err_a),
        .o_drop_count     (drop_a),
        .o_aligned        (al_a)
    );

    smi_tx_word_packer #(.CNT_W(2)) u_dut_sat (
        .i_sys_clk        (clk),
        .i_rst_b          (rst_b),
        .i_enable         (en),
        .i_byte_valid     (bv),
        .i_byte           (b),
        .i_fifo_full      (full),
        .o_fifo_push      (push_s),
        .o_fifo_data      (data_s),
        .o_sync_err_count (err_s),
        .o_drop_count     (drop_s),
        .o_aligned        (al_s)
    );

    // Reference model: bytes of the frame being collected, plus event totals.
    logic [7:0]  cur[$];
    bit          m_push;
    logic [31:0] m_data;
    int          m_err;
    int          m_drop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef SMI_TX_PACKER_STATS_EN
        return (v > mx) ? mx : v;
`else
        return (v > mx) ? 0 : 0;
`endif
    endfunction

    task automatic model_reset();
        cur.delete();
        m_push = 1'b0;
        m_data = '0;
        m_err  = 0;
        m_drop = 0;
    endtask

    task automatic model_edge(input logic e, input logic v, input logic [7:0] x, input logic f);
        logic [31:0] fr;
        m_push = 1'b0;
        if (!e) begin
            cur.delete();
        end else if (v) begin
            case (cur.size())
                0: if (x[7:6] == 2'b10) cur.push_back(x);
                1: cur.push_back(x);
                2: begin
                    if (x[7:6] == 2'b01) begin
                        cur.push_back(x);
                    end else begin
                        m_err++;
                        cur.delete();
                        if (x[7:6] == 2'b10) cur.push_back(x);
                    end
                end
                default: begin
                    fr = {cur[0], cur[1], cur[2], x};
                    cur.delete();
                    if (!f) begin
                        m_push = 1'b1;
                        m_data = fr;
                    end else begin
                        m_drop++;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        check_eq("push",     {31'd0, push_a}, {31'd0, m_push});
        check_eq("data",     data_a, m_data);
        check_eq("aligned",  {31'd0, al_a}, {31'd0, cur.size() != 0});
        check_eq("sync_err", {16'd0, err_a}, exp_cnt(m_err, 16));
        check_eq("drop",     {16'd0, drop_a}, exp_cnt(m_drop, 16));
        check_eq("sat_push", {31'd0, push_s}, {31'd0, m_push});
        check_eq("sat_data", data_s, m_data);
        check_eq("sat_err",  {30'd0, err_s}, exp_cnt(m_err, 2));
        check_eq("sat_drop", {30'd0, drop_s}, exp_cnt(m_drop, 2));
    endtask

    task automatic step(input logic e, input logic v, input logic [7:0] x, input logic f);
        en   = e;
        bv   = v;
        b    = x;
        full = f;
        @(posedge clk);
        model_edge(e, v, x, f);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] x, input logic f);
        step(1'b1, 1'b1, x, f);
    endtask

    // Async reset between edges: outputs must clear before any clock.
    task automatic pulse_reset();
        #2;
        rst_b = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_b = 1'b1;
    endtask

    initial begin
        rst_b = 1'b0;
        en    = 1'b0;
        bv    = 1'b0;
        b     = '0;
        full  = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_b = 1'b1;

        // Clean stream
        send(8'h80, 0); send(8'h12, 0); send(8'h40, 0); send(8'h34, 0);
        check_eq("clean0", data_a, 32'h80124034);
        send(8'h81, 0); send(8'h00, 0); send(8'h7F, 0); send(8'hFF, 0);
        check_eq("clean1", data_a, 32'h81007FFF);
        step(1, 0, 8'h00, 0);

        // Slip
        send(8'h12, 0);
        check_eq("slip_hunt", {31'd0, al_a}, 32'd0);
        send(8'h80, 0);
        check_eq("slip_align", {31'd0, al_a}, 32'd1);
        send(8'hAA, 0); send(8'h40, 0); send(8'h55, 0);
        check_eq("slip_data", data_a, 32'h80AA4055);

        // Bad Q sync with I byte reuse
        send(8'h80, 0); send(8'h11, 0); send(8'h83, 0);
        send(8'h22, 0); send(8'h44, 0); send(8'h55, 0);
        check_eq("badq_data", data_a, 32'h83224455);

        // FIFO full on 4th byte, then a clean frame
        send(8'h80, 0); send(8'h00, 0); send(8'h40, 0); send(8'h00, 1);
        check_eq("full_nopush", {31'd0, push_a}, 32'd0);
        send(8'h82, 1); send(8'h01, 0); send(8'h43, 0); send(8'h04, 0);
        check_eq("full_next", data_a, 32'h82014304);

        // Saturation: five bad-Q frames
        for (int i = 0; i < 5; i++) begin
            send(8'h80, 0); send(8'h11, 0); send(8'h22, 0);
        end

        // Reset mid-word
        send(8'h80, 0); send(8'h00, 0);
        pulse_reset();
        send(8'h40, 0); send(8'h00, 0);
        step(1, 0, 8'h00, 0);

        // Disable mid-word
        send(8'h80, 0); send(8'h00, 0);
        step(0, 1, 8'h40, 0);
        send(8'h40, 0); send(8'h00, 0);
        step(1, 0, 8'h00, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end
            step(($urandom % 32) != 0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/smi_tx_word_packer.md
# smi_tx_word_packer

Packs the byte stream written by the host over the SMI bus into 32-bit I/Q frames and pushes them into the TX FIFO that the LVDS transmitter drains. Enforces the frame sync pattern: I-word MSBs `10`, Q-word MSBs `01`. It re-aligns after byte slips and drops whole frames, never partial ones, when the FIFO is full. Sits between the SMI write interface and the TX FIFO write port, in the system clock domain.

## Interface
Parameters:
- `CNT_W`, default 16, width of the saturating diagnostic counters.

Ports:
- `i_sys_clk`, in, 1: the block's only clock. All logic is on the rising edge.
- `i_rst_b`, in, 1: asynchronous, active-low reset.
- `i_enable`, in, 1: TX path enabled. Low forces HUNT and suppresses pushes.
- `i_byte_valid`, in, 1: a byte is presented this cycle. There is no backpressure. May be high every cycle.
- `i_byte`, in, 8: SMI byte. Arrival order is `word[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
- `i_fifo_full`, in, 1: TX FIFO full.
- `o_fifo_push`, out, 1: one-cycle FIFO write strobe.
- `o_fifo_data`, out, 32: assembled frame.
- `o_sync_err_count`, out, `CNT_W`: pattern violations, saturating.
- `o_drop_count`, out, `CNT_W`: frames dropped on full, saturating.
- `o_aligned`, out, 1: high while the FSM is in B1..B3.

## Operation
FSM states are HUNT, B1, B2 and B3. Each state names the index of the next expected byte. State changes only on accepted bytes: `i_byte_valid && i_enable`.

- **HUNT**: if the byte has `[7:6]==2'b10`, latch it into `[31:24]` and go to B1. Otherwise discard it.
- **B1**: latch the byte into `[23:16]` and go to B2. Content is not checked.
- **B2**: if the byte has `[7:6]==2'b01`, latch it into `[15:8]` and go to B3. Otherwise:
  - increment the sync error count;
  - if the byte has `[7:6]==2'b10`, treat it as a new byte 0 and go to B1;
  - otherwise go to HUNT.
- **B3**: latch the byte into `[7:0]` and return to B1-expecting-byte-0, which is HUNT. The next word must resync on its own byte 0. The completed frame is then resolved:
  - if `i_fifo_full==0`, push the frame;
  - otherwise, drop the frame and increment the drop count.
- **`i_enable` low**: synchronously go to HUNT, clear the partial word, and assert no push. Any push already registered in the output stage still completes that cycle.
- **Counters**: saturate at all-ones and never wrap. They clear only on reset.
- **Simultaneous events**: a byte error and a drop cannot coincide because each needs a different state. A push and a new byte 0 in the same cycle are both honoured.

## Timing
- Reset values: `o_fifo_push=0`, `o_fifo_data=0`, both counters 0, `o_aligned=0`, state HUNT.
- Latency: `o_fifo_push` and `o_fifo_data` are registered. They are asserted the cycle after the 4th byte is accepted.
- `o_fifo_data` holds its value until the next push.
- `i_fifo_full` is sampled in the cycle the 4th byte is accepted. A FIFO that goes full one cycle later does not affect that frame.
- Sustained throughput is 1 byte/cycle, giving 1 frame per 4 cycles.
- Reset asserted mid-word discards the partial word immediately and asynchronously.

## Configuration
- With `SMI_TX_PACKER_STATS_EN` defined:
  - both counters are implemented as specified;
  - the drop logic is unchanged.
- Without it:
  - `o_sync_err_count` and `o_drop_count` are tied to 0 and no counter flops are built;
  - all framing, resync and drop behaviour is identical.

## Structure
- The shared package holds:
  - sync pattern constants: I `2'b10`, Q `2'b01`;
  - the frame byte-order constant;
  - the FSM state encoding, 2 bits.
- The LVDS transmitter reuses these constants, so the packer and the transmitter cannot disagree on the sync bits.
- One sub-module: `sat_counter`, parameterised width, increment enable, saturating. It is instantiated twice under the macro.

## Test plan
- **Clean stream**: bytes `80 12 40 34`, `81 00 7F FF` back-to-back with `i_fifo_full=0` → pushes `0x80124034`, then `0x81007FFF`, each 1 cycle after the 4th byte. Both counters stay 0.
- **Slip**: `12 80 AA 40 55` → `12` is discarded in HUNT, and the push is `0x80AA4055`. `o_aligned` rises on the `80` byte.
- **Bad Q sync**: `80 11 83 22 44 55` → the sync error count becomes 1, `83` is reused as byte 0, and the push is `0x83224455`.
- **FIFO full**: `i_fifo_full=1` during the 4th byte of `80 00 40 00` → no push and the drop count becomes 1. The next frame, with full deasserted, is pushed.
- **Saturation**, run with `CNT_W=2` and stats enabled: 5 bad-Q frames → the sync error count stays at 3. Without the macro → reads 0.
- **Reset and disable mid-word**:
  - assert `i_rst_b=0` after 2 bytes → all outputs return to reset values immediately, and the following `40 00` produces no push;
  - repeat with `i_enable` low → same result, with no counter change.
